// File: rtl/evo_xb_pmux_ctrl.sv
// evo_xb_pmux_ctrl: CSR-programmable per-pin XB source select
// with an owner-change guard gap and an OR-able Avalon-MM CSR slave.
module evo_xb_pmux_ctrl #(
  parameter int DWIDTH       = 8,
  parameter int NUM_XB       = 4,
  parameter int CSR_AWIDTH   = 16,
  parameter int CSR_DWIDTH   = 32,
  parameter int BASE_ADDR    = 'h0100,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_XB*DWIDTH-1:0] xb_dir_i,
  input  logic [NUM_XB*DWIDTH-1:0] xb_out_i,
  input  logic [NUM_XB*DWIDTH-1:0] xb_en_i,
  output logic [DWIDTH-1:0]        pmux_dir_o,
  output logic [DWIDTH-1:0]        pmux_out_o,
  output logic [DWIDTH-1:0]        pmux_en_o,
  output logic                     locked_o,
  input  logic [CSR_AWIDTH-1:0]    avs_csr_address,
  input  logic                     avs_csr_read,
  input  logic                     avs_csr_write,
  input  logic [CSR_DWIDTH-1:0]    avs_csr_writedata,
  output logic [CSR_DWIDTH-1:0]    avs_csr_readdata,
  output logic                     avs_csr_readdatavalid,
  output logic                     avs_csr_waitrequest
);
  localparam int SELW = $clog2(NUM_XB + 1);
  localparam int CW   = $clog2(GUARD_CYCLES + 1);
  localparam int OW   = CSR_AWIDTH + 1;

  typedef enum logic {ST_STABLE, ST_GUARD} pin_st_t;

  pin_st_t         st_q   [DWIDTH];
  pin_st_t         st_d   [DWIDTH];
  logic [SELW-1:0] own_q  [DWIDTH];
  logic [SELW-1:0] own_d  [DWIDTH];
  logic [SELW-1:0] pend_q [DWIDTH];
  logic [SELW-1:0] pend_d [DWIDTH];
  logic [CW-1:0]   cnt_q  [DWIDTH];
  logic [CW-1:0]   cnt_d  [DWIDTH];

  logic                  lock_q, lock_d;
  logic [OW-1:0]         off;
  logic                  mapped, ctrl_sel, pin_wr, rd_hit;
  logic [DWIDTH-1:0]     pin_hit;
  logic [SELW-1:0]       req;
  logic [CSR_DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0]     dir_d, out_d, en_d;
  logic                  unused_wdata;

  // Extra top bit keeps addresses below BASE_ADDR out of the map.
  assign off      = {1'b0, avs_csr_address} - OW'(BASE_ADDR);
  assign mapped   = off <= OW'(DWIDTH);
  assign ctrl_sel = off == OW'(DWIDTH);
  assign rd_hit   = avs_csr_read && mapped;
  assign pin_wr   = avs_csr_write && mapped && !ctrl_sel && !lock_q;
  assign req      = (avs_csr_writedata[SELW-1:0] > SELW'(NUM_XB)) ?
                    '0 : avs_csr_writedata[SELW-1:0];
  assign lock_d   = lock_q | (avs_csr_write & ctrl_sel &
                              avs_csr_writedata[0]);
  assign unused_wdata = ^avs_csr_writedata[CSR_DWIDTH-1:SELW];

  always_comb begin
    pin_hit = '0;
    for (int i = 0; i < DWIDTH; i++)
      pin_hit[i] = pin_wr && (off == OW'(i));
  end

  always_comb begin
    for (int i = 0; i < DWIDTH; i++) begin
      st_d[i]   = st_q[i];
      own_d[i]  = own_q[i];
      pend_d[i] = pend_q[i];
      cnt_d[i]  = cnt_q[i];
      unique case (st_q[i])
        ST_STABLE: begin
          if (pin_hit[i] && req != own_q[i]) begin
            st_d[i]   = ST_GUARD;
            own_d[i]  = '0;
            pend_d[i] = req;
            cnt_d[i]  = CW'(GUARD_CYCLES);
          end
        end
        ST_GUARD: begin
          if (pin_hit[i]) begin
            pend_d[i] = req;
            cnt_d[i]  = CW'(GUARD_CYCLES);
          end else if (cnt_q[i] == CW'(1)) begin
            st_d[i]  = ST_STABLE;
            own_d[i] = pend_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DWIDTH; i++) begin
        st_q[i]   <= ST_STABLE;
        own_q[i]  <= '0;
        pend_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      lock_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      own_q  <= own_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  always_comb begin
    rd_word = '0;
    if (ctrl_sel)
      rd_word[0] = lock_q;
    for (int i = 0; i < DWIDTH; i++) begin
      if (off == OW'(i)) begin
        rd_word[8]        = (st_q[i] == ST_GUARD);
        rd_word[SELW-1:0] = own_q[i];
      end
    end
  end

  always_comb begin
    dir_d = '0;
    out_d = '0;
    en_d  = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      for (int k = 0; k < NUM_XB; k++) begin
        if (own_q[i] == SELW'(k + 1)) begin
          dir_d[i] = xb_dir_i[k*DWIDTH+i];
          out_d[i] = xb_out_i[k*DWIDTH+i];
          en_d[i]  = xb_en_i[k*DWIDTH+i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmux_dir_o            <= '0;
      pmux_out_o            <= '0;
      pmux_en_o             <= '0;
      avs_csr_readdata      <= '0;
      avs_csr_readdatavalid <= 1'b0;
    end else begin
      pmux_dir_o            <= dir_d;
      pmux_out_o            <= out_d;
      pmux_en_o             <= en_d;
      avs_csr_readdata      <= rd_hit ? rd_word : '0;
      avs_csr_readdatavalid <= rd_hit;
    end
  end

  assign locked_o            = lock_q;
  assign avs_csr_waitrequest = 1'b0;

endmodule

// File: tb/tb_evo_xb_pmux_ctrl.sv
// tb_evo_xb_pmux_ctrl: random + directed stimulus against a
// time-stamped owner/guard reference model.
module tb_evo_xb_pmux_ctrl;
  localparam int DW   = 8;
  localparam int NXB  = 4;
  localparam int AW   = 16;
  localparam int CDW  = 32;
  localparam int BASE = 'h0100;
  localparam int G    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NXB*DW-1:0] xb_dir, xb_out, xb_en;
  logic [DW-1:0]     pdir, pout, pen;
  logic              locked;
  logic [AW-1:0]     addr;
  logic              rd, wr, rdv, wreq;
  logic [CDW-1:0]    wdata, rdata;

  evo_xb_pmux_ctrl #(
    .DWIDTH(DW), .NUM_XB(NXB), .CSR_AWIDTH(AW),
    .CSR_DWIDTH(CDW), .BASE_ADDR(BASE), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .reset(reset),
    .xb_dir_i(xb_dir), .xb_out_i(xb_out), .xb_en_i(xb_en),
    .pmux_dir_o(pdir), .pmux_out_o(pout), .pmux_en_o(pen),
    .locked_o(locked),
    .avs_csr_address(addr), .avs_csr_read(rd),
    .avs_csr_write(wr), .avs_csr_writedata(wdata),
    .avs_csr_readdata(rdata), .avs_csr_readdatavalid(rdv),
    .avs_csr_waitrequest(wreq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Settled owner, pending owner and the edge at which it takes over
  // (-1 when no change is in flight).
  int m_own  [DW];
  int m_pend [DW];
  int m_at   [DW];
  bit m_lock;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int view(int p);
    return (m_at[p] >= 0) ? 0 : m_own[p];
  endfunction

  task automatic settle();
    for (int p = 0; p < DW; p++)
      if (m_at[p] >= 0 && cyc >= m_at[p]) begin
        m_own[p] = m_pend[p];
        m_at[p]  = -1;
      end
  endtask

  task automatic model_reset();
    for (int p = 0; p < DW; p++) begin
      m_own[p]  = 0;
      m_pend[p] = 0;
      m_at[p]   = -1;
    end
    m_lock = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_dir"}, 32'(pdir), 0);
    chk({tag, "_out"}, 32'(pout), 0);
    chk({tag, "_en"}, 32'(pen), 0);
    chk({tag, "_rdv"}, 32'(rdv), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_lock"}, 32'(locked), 0);
  endtask

  // One clock: drive an optional CSR op plus random XB inputs,
  // predict the registered response and compare after the edge.
  task automatic step(bit r, bit w, int off, int data);
    logic [DW-1:0] e_dir, e_out, e_en;
    logic          e_rdv;
    logic [31:0]   e_rdata;
    int            own, v;
    @(negedge clk);
    xb_dir = $urandom;
    xb_out = $urandom;
    xb_en  = $urandom;
    addr   = AW'(BASE + off);
    rd     = r;
    wr     = w;
    wdata  = CDW'(data);
    settle();
    for (int p = 0; p < DW; p++) begin
      own = view(p);
      e_dir[p] = (own != 0) ? xb_dir[(own-1)*DW+p] : 1'b0;
      e_out[p] = (own != 0) ? xb_out[(own-1)*DW+p] : 1'b0;
      e_en[p]  = (own != 0) ? xb_en[(own-1)*DW+p]  : 1'b0;
    end
    e_rdv   = r && off >= 0 && off <= DW;
    e_rdata = 0;
    if (e_rdv)
      e_rdata = (off == DW) ? 32'(m_lock) :
                ((m_at[off] >= 0) ? 32'h100 : 0) | 32'(view(off));
    if (w && off >= 0 && off < DW && !m_lock) begin
      v = data % 8;
      if (v > NXB) v = 0;
      if (m_at[off] >= 0 || v != m_own[off]) begin
        m_pend[off] = v;
        m_at[off]   = cyc + 1 + G;
      end
    end
    if (w && off == DW && data[0]) m_lock = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    chk("pmux_dir", 32'(pdir), 32'(e_dir));
    chk("pmux_out", 32'(pout), 32'(e_out));
    chk("pmux_en", 32'(pen), 32'(e_en));
    chk("rdv", 32'(rdv), 32'(e_rdv));
    chk("rdata", rdata, e_rdata);
    chk("locked", 32'(locked), 32'(m_lock));
    chk("waitreq", 32'(wreq), 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic rand_ops(int n);
    int off, d;
    for (int i = 0; i < n; i++) begin
      off = int'($urandom_range(0, 10)) - 1;
      d   = int'($urandom_range(0, 15));
      if (off == DW) d = d & ~1;
      step(1'($urandom), 1'($urandom), off, d);
    end
  endtask

  initial begin
    reset = 1'b1;
    xb_dir = '0; xb_out = '0; xb_en = '0;
    addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i <= DW; i++) step(1, 0, i, 0);

    step(0, 1, 3, 2);
    idle(5);
    step(0, 1, 3, 3);
    step(1, 0, 3, 0);
    idle(4);

    step(0, 1, 5, 7);
    step(1, 0, 5, 0);
    step(1, 0, 9, 0);
    step(1, 0, -1, 0);
    step(1, 1, 2, 1);
    step(1, 0, 2, 0);
    step(0, 1, 4, 1);
    step(0, 1, 4, 1);
    step(0, 1, 4, 2);
    idle(4);

    rand_ops(600);

    step(0, 1, DW, 1);
    step(0, 1, 0, 1);
    step(0, 1, DW, 0);
    step(1, 0, 0, 0);
    step(1, 0, DW, 0);
    rand_ops(60);

    step(0, 1, 1, 4);
    idle(1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    step(0, 1, 2, 3);
    idle(3);
    step(0, 1, 6, 1);
    step(1, 0, 6, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("guard_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1, 0, 6, 0);
    step(1, 0, DW, 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
